can_tx_scheduler: RTL and testbench
===================================

Name: can_tx_scheduler

Overview:
- Shares the single CAN frame transmitter (custom CAN node datapath) between N_MB transmit mailboxes.
- Picks the pending mailbox with the lowest 11-bit ID (highest CAN priority) and waits for bus idle before launching.
- Hands the frame to the transmitter with a start/done/lost-arbitration handshake, retries on lost arbitration, and reports success or failure per mailbox.

Parameters:
- N_MB, 4, number of requesting mailboxes (2..8).
- IDLE_BITS, 11, consecutive recessive bus bits required before launch.
- MAX_RETRY, 7, lost-arbitration retries per mailbox before abandoning.
- TX_TIMEOUT, 200, can_clk cycles in ACTIVE before watchdog abort.

Ports:
- can_clk  in  1  CAN bit clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  N_MB  mailbox i has a frame pending; held high until ack or fail.
- req_id  in  N_MB*11  packed IDs; mailbox i at [11*i+10:11*i].
- req_dlc  in  N_MB*4  packed DLCs (0..8; values >8 clamp to 8).
- req_data  in  N_MB*64  packed payloads; byte 0 at MSBs of each slice.
- req_ack  out  N_MB  one-cycle pulse: frame of mailbox i sent.
- req_fail  out  N_MB  one-cycle pulse: mailbox i abandoned (retries or timeout).
- tx_start  out  1  one-cycle launch pulse to the transmitter.
- tx_id  out  11  ID of launched frame.
- tx_dlc  out  4  DLC of launched frame.
- tx_data  out  64  payload of launched frame.
- tx_done  in  1  transmitter finished frame (pulse).
- tx_lost_arb  in  1  transmitter lost arbitration (pulse).
- can_rx_bit  in  1  sampled bus level; 1 = recessive.
- owner  out  clog2(N_MB)  index of the mailbox currently owning the transmitter.
- sched_busy  out  1  high in LAUNCH or ACTIVE.

Behaviour:
- Reset values:
  - All outputs 0 and state IDLE.
  - Idle counter 0.
  - All retry counters 0.
- Idle counter:
  - Increments on can_rx_bit=1 and saturates at IDLE_BITS.
  - Clears to 0 on can_rx_bit=0.
  - bus_idle = (count==IDLE_BITS).
- States:
  - IDLE: if any req_valid, go to WAIT_BUS.
  - WAIT_BUS: if no req_valid, go to IDLE. If bus_idle, go to SELECT.
  - SELECT:
    - Combinational minimum over valid mailboxes; equal IDs resolve to the lower index.
    - Registers owner and latches tx_id/tx_dlc/tx_data.
    - Goes to LAUNCH. If no req_valid remains, goes to IDLE.
  - LAUNCH: tx_start=1 for exactly this cycle; go to ACTIVE and clear the watchdog.
  - ACTIVE:
    - On tx_done: req_ack[owner] pulse next cycle, clear retry[owner], go to IDLE.
    - On tx_lost_arb: if retry[owner]==MAX_RETRY, pulse req_fail[owner], clear retry[owner], go to IDLE. Otherwise increment retry[owner] and go to WAIT_BUS.
    - Watchdog reaching TX_TIMEOUT: req_fail[owner], clear retry[owner], go to IDLE.
- Latency: with bus_idle already true and a request arriving in IDLE, tx_start asserts 3 cycles later (WAIT_BUS, SELECT, LAUNCH).
- tx_id/tx_dlc/tx_data are stable from LAUNCH until exit from ACTIVE, and unchanged while not in LAUNCH or ACTIVE.
- Simultaneous events:
  - tx_done and tx_lost_arb in the same cycle: done wins.
  - tx_done or tx_lost_arb outside ACTIVE: ignored.
- req_valid[owner] dropped during ACTIVE: the frame completes and ack/fail is still pulsed; the requester ignores it.
- Re-selection after lost arbitration is a fresh minimum, so a newly arrived higher-priority mailbox preempts the retrying one. Its retry count is preserved.
- Reset mid-frame: return to IDLE with no ack/fail pulse; the transmitter is reset by the same reset.
- req_ack and req_fail are never high in the same cycle, and at most one bit of each is high.

Decomposition:
- Shared package can_pkg: state encoding (IDLE, WAIT_BUS, SELECT, LAUNCH, ACTIVE), CAN_ID_W=11, CAN_DLC_W=4, CAN_DATA_W=64, RECESSIVE=1'b1.
- Sub-module can_prio_select: combinational lowest-ID, lowest-index finder over N_MB valid IDs. Outputs grant index and any_valid.

Test Plan:
- Single request: mailbox 2 with id 0x123, dlc 1, data 0x89.., bus recessive ≥11 bits → tx_start 3 cycles after req_valid, tx_id=0x123; tx_done → req_ack[2] pulse, state IDLE.
- Priority: mailboxes 0 (0x456), 1 (0x123), 3 (0x123) valid → mailbox 1 sent first, then 3, then 0, in three frames with three acks in order.
- Bus busy: can_rx_bit=0 every 5th cycle → no tx_start. After 11 consecutive 1s → tx_start on the next SELECT→LAUNCH.
- Lost arbitration: 8 consecutive tx_lost_arb for mailbox 0 (MAX_RETRY=7) → 7 relaunches, then req_fail[0]; retry[0] cleared.
- Watchdog: no tx_done for 200 cycles after tx_start → req_fail[owner] pulse; tx_done arriving later is ignored.
- Reset asserted in ACTIVE → next cycle all outputs 0, no ack/fail. Coincident tx_done+tx_lost_arb → ack only.

Source files
------------

// File: rtl/can_pkg.sv
// Shared definitions for the CAN transmit scheduler slice.
//   - field widths of a CAN frame (ID, DLC, payload)
//   - recessive bus level
//   - scheduler state encoding
//   - helpers: index width for N requesters, DLC clamp to 8
package can_pkg;

  localparam int unsigned CAN_ID_W   = 11;
  localparam int unsigned CAN_DLC_W  = 4;
  localparam int unsigned CAN_DATA_W = 64;
  localparam logic        RECESSIVE  = 1'b1;
  localparam logic [CAN_DLC_W-1:0] CAN_MAX_DLC = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BUS,
    S_SELECT,
    S_LAUNCH,
    S_ACTIVE
  } sched_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [CAN_DLC_W-1:0] clamp_dlc(input logic [CAN_DLC_W-1:0] dlc);
    return (dlc > CAN_MAX_DLC) ? CAN_MAX_DLC : dlc;
  endfunction

endpackage

// File: rtl/can_prio_select.sv
// Combinational priority finder: among the valid mailboxes, returns the one
// with the numerically lowest ID; equal IDs resolve to the lower index.
//   valid     in  N_MB            per-mailbox valid
//   ids       in  N_MB*CAN_ID_W   packed IDs, mailbox i at [11*i +: 11]
//   grant     out idx_width(N_MB) winning mailbox index (0 when none valid)
//   any_valid out 1               at least one mailbox valid
module can_prio_select
  import can_pkg::*;
#(
  parameter int unsigned N_MB = 4
) (
  input  logic [N_MB-1:0]             valid,
  input  logic [N_MB*CAN_ID_W-1:0]    ids,
  output logic [idx_width(N_MB)-1:0]  grant,
  output logic                        any_valid
);

  localparam int unsigned IDX_W = idx_width(N_MB);

  logic [CAN_ID_W-1:0] best_id;

  // Strict less-than while scanning upward keeps the lower index on ties.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    best_id   = '1;
    for (int unsigned i = 0; i < N_MB; i++) begin
      if (valid[i] && (!any_valid || (ids[i*CAN_ID_W +: CAN_ID_W] < best_id))) begin
        any_valid = 1'b1;
        best_id   = ids[i*CAN_ID_W +: CAN_ID_W];
        grant     = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// Shares one CAN frame transmitter between N_MB transmit mailboxes.
// Waits for IDLE_BITS recessive bits, launches the highest-priority (lowest
// ID) pending mailbox, retries on lost arbitration up to MAX_RETRY times and
// aborts after TX_TIMEOUT cycles without completion.
//   can_clk, reset                 clock, synchronous active-high reset
//   req_valid/id/dlc/data   in     per-mailbox packed requests
//   req_ack, req_fail       out    one-cycle per-mailbox completion pulses
//   tx_start/id/dlc/data    out    launch handshake to the transmitter
//   tx_done, tx_lost_arb    in     transmitter result pulses
//   can_rx_bit              in     sampled bus level (1 = recessive)
//   owner                   out    mailbox currently owning the transmitter
//   sched_busy              out    high in LAUNCH or ACTIVE
module can_tx_scheduler
  import can_pkg::*;
#(
  parameter int unsigned N_MB       = 4,
  parameter int unsigned IDLE_BITS  = 11,
  parameter int unsigned MAX_RETRY  = 7,
  parameter int unsigned TX_TIMEOUT = 200
) (
  input  logic                         can_clk,
  input  logic                         reset,
  input  logic [N_MB-1:0]              req_valid,
  input  logic [N_MB*CAN_ID_W-1:0]     req_id,
  input  logic [N_MB*CAN_DLC_W-1:0]    req_dlc,
  input  logic [N_MB*CAN_DATA_W-1:0]   req_data,
  output logic [N_MB-1:0]              req_ack,
  output logic [N_MB-1:0]              req_fail,
  output logic                         tx_start,
  output logic [CAN_ID_W-1:0]          tx_id,
  output logic [CAN_DLC_W-1:0]         tx_dlc,
  output logic [CAN_DATA_W-1:0]        tx_data,
  input  logic                         tx_done,
  input  logic                         tx_lost_arb,
  input  logic                         can_rx_bit,
  output logic [idx_width(N_MB)-1:0]   owner,
  output logic                         sched_busy
);

  localparam int unsigned OWN_W   = idx_width(N_MB);
  localparam int unsigned IDLE_W  = $clog2(IDLE_BITS + 1);
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned WD_W    = $clog2(TX_TIMEOUT + 1);

  sched_state_t        state, state_next;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                bus_idle;
  logic [RETRY_W-1:0]  retry [N_MB];
  logic [WD_W-1:0]     wd_cnt;
  logic [OWN_W-1:0]    grant;
  logic                any_valid;
  logic                latch_sel, ev_ack, ev_fail, ev_retry;

  can_prio_select #(.N_MB(N_MB)) u_prio (
    .valid     (req_valid),
    .ids       (req_id),
    .grant     (grant),
    .any_valid (any_valid)
  );

  assign bus_idle   = (idle_cnt == IDLE_W'(IDLE_BITS));
  assign tx_start   = (state == S_LAUNCH);
  assign sched_busy = (state == S_LAUNCH) || (state == S_ACTIVE);

  always_ff @(posedge can_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch_sel  = 1'b0;
    ev_ack     = 1'b0;
    ev_fail    = 1'b0;
    ev_retry   = 1'b0;
    unique case (state)
      S_IDLE:     if (|req_valid) state_next = S_WAIT_BUS;
      S_WAIT_BUS: begin
        if (!(|req_valid))  state_next = S_IDLE;
        else if (bus_idle)  state_next = S_SELECT;
      end
      S_SELECT: begin
        if (any_valid) begin
          latch_sel  = 1'b1;
          state_next = S_LAUNCH;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_LAUNCH:   state_next = S_ACTIVE;
      S_ACTIVE: begin
        // Done outranks lost arbitration, which outranks the watchdog.
        if (tx_done) begin
          ev_ack     = 1'b1;
          state_next = S_IDLE;
        end else if (tx_lost_arb) begin
          if (retry[owner] == RETRY_W'(MAX_RETRY)) begin
            ev_fail    = 1'b1;
            state_next = S_IDLE;
          end else begin
            ev_retry   = 1'b1;
            state_next = S_WAIT_BUS;
          end
        end else if (wd_cnt == WD_W'(TX_TIMEOUT - 1)) begin
          ev_fail    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge can_clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (can_rx_bit != RECESSIVE) begin
      idle_cnt <= '0;
    end else if (!bus_idle) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  always_ff @(posedge can_clk) begin
    if (reset) begin
      owner    <= '0;
      tx_id    <= '0;
      tx_dlc   <= '0;
      tx_data  <= '0;
      req_ack  <= '0;
      req_fail <= '0;
      wd_cnt   <= '0;
      for (int unsigned i = 0; i < N_MB; i++) retry[i] <= '0;
    end else begin
      req_ack  <= '0;
      req_fail <= '0;
      if (latch_sel) begin
        owner   <= grant;
        tx_id   <= req_id[int'(grant)*CAN_ID_W +: CAN_ID_W];
        tx_dlc  <= clamp_dlc(req_dlc[int'(grant)*CAN_DLC_W +: CAN_DLC_W]);
        tx_data <= req_data[int'(grant)*CAN_DATA_W +: CAN_DATA_W];
      end
      // Watchdog counts cycles spent in ACTIVE; zero on the first ACTIVE cycle.
      if (state == S_LAUNCH)      wd_cnt <= '0;
      else if (state == S_ACTIVE) wd_cnt <= wd_cnt + WD_W'(1);
      if (ev_ack) begin
        req_ack[owner] <= 1'b1;
        retry[owner]   <= '0;
      end
      if (ev_fail) begin
        req_fail[owner] <= 1'b1;
        retry[owner]    <= '0;
      end
      if (ev_retry) retry[owner] <= retry[owner] + RETRY_W'(1);
    end
  end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler: directed scenarios followed by a
// randomized phase, all checked against a transaction-level mailbox model.
module tb_can_tx_scheduler;

  localparam int unsigned N_MB       = 4;
  localparam int unsigned IDLE_BITS  = 11;
  localparam int unsigned MAX_RETRY  = 7;
  localparam int unsigned TX_TIMEOUT = 200;

  logic              can_clk = 1'b0;
  logic              reset;
  logic [N_MB-1:0]   req_valid;
  logic [N_MB*11-1:0] req_id;
  logic [N_MB*4-1:0] req_dlc;
  logic [N_MB*64-1:0] req_data;
  logic [N_MB-1:0]   req_ack, req_fail;
  logic              tx_start;
  logic [10:0]       tx_id;
  logic [3:0]        tx_dlc;
  logic [63:0]       tx_data;
  logic              tx_done, tx_lost_arb, can_rx_bit;
  logic [1:0]        owner;
  logic              sched_busy;

  always #5 can_clk = ~can_clk;

  can_tx_scheduler #(
    .N_MB(N_MB), .IDLE_BITS(IDLE_BITS), .MAX_RETRY(MAX_RETRY), .TX_TIMEOUT(TX_TIMEOUT)
  ) dut (
    .can_clk(can_clk), .reset(reset),
    .req_valid(req_valid), .req_id(req_id), .req_dlc(req_dlc), .req_data(req_data),
    .req_ack(req_ack), .req_fail(req_fail),
    .tx_start(tx_start), .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
    .tx_done(tx_done), .tx_lost_arb(tx_lost_arb), .can_rx_bit(can_rx_bit),
    .owner(owner), .sched_busy(sched_busy)
  );

  int n_asserts = 0;
  int n_fails   = 0;

  // Mailbox model: what each requester currently holds and its retry count.
  bit          mb_v     [N_MB];
  logic [10:0] mb_id    [N_MB];
  logic [3:0]  mb_dlc   [N_MB];
  logic [63:0] mb_data  [N_MB];
  int          mb_retry [N_MB];
  int          cur;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge can_clk);
    #1;
    check("ack_fail_exclusive",
          64'($onehot0(req_ack) && $onehot0(req_fail) && !((|req_ack) && (|req_fail))), 64'(1));
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N_MB; i++) begin
      req_valid[i]         = mb_v[i];
      req_id[i*11 +: 11]   = mb_id[i];
      req_dlc[i*4 +: 4]    = mb_dlc[i];
      req_data[i*64 +: 64] = mb_data[i];
    end
  endtask

  task automatic set_mb(input int i, input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    mb_v[i] = 1'b1; mb_id[i] = id; mb_dlc[i] = dlc; mb_data[i] = data;
  endtask

  // Highest CAN priority = lowest ID; ties go to the lowest mailbox index.
  function automatic int pick();
    int best = -1;
    for (int i = 0; i < N_MB; i++)
      if (mb_v[i] && (best < 0 || mb_id[i] < mb_id[best])) best = i;
    return best;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   64'(req_ack),    64'(0));
    check({tag, "_fail"},  64'(req_fail),   64'(0));
    check({tag, "_start"}, 64'(tx_start),   64'(0));
    check({tag, "_id"},    64'(tx_id),      64'(0));
    check({tag, "_dlc"},   64'(tx_dlc),     64'(0));
    check({tag, "_data"},  tx_data,         64'(0));
    check({tag, "_owner"}, 64'(owner),      64'(0));
    check({tag, "_busy"},  64'(sched_busy), 64'(0));
  endtask

  task automatic wait_start(input int exp_lat);
    int n = 0;
    do begin
      tick();
      n++;
    end while (tx_start !== 1'b1 && n < 100);
    check("start_seen", 64'(tx_start), 64'(1));
    if (exp_lat >= 0) check("start_latency", 64'(n), 64'(exp_lat));
    cur = pick();
    if (tx_start === 1'b1 && cur >= 0) begin
      check("owner",   64'(owner),  64'(cur));
      check("tx_id",   64'(tx_id),  64'(mb_id[cur]));
      check("tx_dlc",  64'(tx_dlc), 64'((mb_dlc[cur] > 4'd8) ? 4'd8 : mb_dlc[cur]));
      check("tx_data", tx_data,     mb_data[cur]);
      check("busy_launch", 64'(sched_busy), 64'(1));
    end
  endtask

  task automatic finish_frame(input bit done, input bit lost, input int delay);
    logic [N_MB-1:0] exp_ack, exp_fail;
    tick();
    check("start_one_cycle", 64'(tx_start),   64'(0));
    check("busy_active",     64'(sched_busy), 64'(1));
    repeat (delay) tick();
    tx_done     = done;
    tx_lost_arb = lost;
    exp_ack  = '0;
    exp_fail = '0;
    if (done) begin
      exp_ack[cur] = 1'b1; mb_retry[cur] = 0; mb_v[cur] = 1'b0;
    end else if (lost) begin
      if (mb_retry[cur] == MAX_RETRY) begin
        exp_fail[cur] = 1'b1; mb_retry[cur] = 0; mb_v[cur] = 1'b0;
      end else begin
        mb_retry[cur]++;
      end
    end
    tick();
    tx_done     = 1'b0;
    tx_lost_arb = 1'b0;
    check("req_ack",  64'(req_ack),  64'(exp_ack));
    check("req_fail", 64'(req_fail), 64'(exp_fail));
    drive_reqs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r, early;
    reset = 1'b1; tx_done = 1'b0; tx_lost_arb = 1'b0; can_rx_bit = 1'b1;
    for (int i = 0; i < N_MB; i++) begin
      mb_v[i] = 1'b0; mb_id[i] = '0; mb_dlc[i] = '0; mb_data[i] = '0; mb_retry[i] = 0;
    end
    drive_reqs();
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    repeat (IDLE_BITS + 1) tick();

    // Single request, bus already idle: launch three cycles after request.
    set_mb(2, 11'h123, 4'd1, 64'h89AB_CDEF_0123_4567);
    drive_reqs();
    wait_start(3);
    finish_frame(1'b1, 1'b0, 2);
    tick();
    check("idle_after_ack", 64'(sched_busy), 64'(0));
    check("ack_one_cycle",  64'(req_ack),    64'(0));

    // Priority with a tie: mailbox 1, then 3, then 0.
    set_mb(0, 11'h456, 4'd8,  64'h0000_1111_2222_3333);
    set_mb(1, 11'h123, 4'd9,  64'h4444_5555_6666_7777);
    set_mb(3, 11'h123, 4'd15, 64'h8888_9999_AAAA_BBBB);
    drive_reqs();
    for (int k = 0; k < 3; k++) begin
      wait_start(3);
      check("prio_order", 64'(cur), 64'((k == 0) ? 1 : (k == 1) ? 3 : 0));
      finish_frame(1'b1, 1'b0, 1);
    end

    // Bus busy: a dominant bit every fifth cycle holds off the launch.
    can_rx_bit = 1'b0;
    tick();
    set_mb(1, 11'h200, 4'd3, 64'hDEAD_BEEF_0000_0001);
    drive_reqs();
    early = 0;
    for (int c = 0; c < 40; c++) begin
      can_rx_bit = (c % 5 == 4) ? 1'b0 : 1'b1;
      tick();
      if (tx_start === 1'b1) early++;
    end
    check("no_start_bus_busy", 64'(early), 64'(0));
    can_rx_bit = 1'b1;
    wait_start(IDLE_BITS + 2);
    finish_frame(1'b1, 1'b0, 0);

    // Lost arbitration: 8 losses give 7 relaunches then a fail.
    set_mb(0, 11'h0AA, 4'd2, 64'h0102_0304_0506_0708);
    drive_reqs();
    wait_start(3);
    for (int k = 0; k < 8; k++) begin
      finish_frame(1'b0, 1'b1, 1);
      if (k < 7) wait_start(2);
    end
    check("retry_fail_cleared_valid", 64'(req_valid), 64'(0));
    // Retry count was cleared: a new single loss does not fail.
    set_mb(0, 11'h0AB, 4'd4, 64'h1111_2222_3333_4444);
    drive_reqs();
    wait_start(3);
    finish_frame(1'b0, 1'b1, 0);
    wait_start(2);
    finish_frame(1'b1, 1'b0, 0);

    // Watchdog: no completion within TX_TIMEOUT ACTIVE cycles.
    set_mb(3, 11'h7FF, 4'd0, 64'h0);
    drive_reqs();
    wait_start(3);
    early = 0;
    for (int k = 1; k <= TX_TIMEOUT; k++) begin
      tick();
      if (|req_fail) early++;
    end
    check("wd_no_early_fail", 64'(early), 64'(0));
    tick();
    check("wd_fail", 64'(req_fail), 64'(4'b1000));
    check("wd_no_ack", 64'(req_ack), 64'(0));
    mb_v[3] = 1'b0; mb_retry[3] = 0;
    drive_reqs();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    check("late_done_ignored", 64'(req_ack), 64'(0));
    check("late_done_idle",    64'(sched_busy), 64'(0));

    // Reset in ACTIVE: everything returns to zero with no pulse.
    set_mb(2, 11'h050, 4'd5, 64'hCAFE_F00D_1234_5678);
    drive_reqs();
    wait_start(3);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check_all_zero("mid_reset");
    reset = 1'b0;
    for (int i = 0; i < N_MB; i++) mb_retry[i] = 0;
    // Coincident done and lost arbitration: acknowledge only.
    wait_start(-1);
    finish_frame(1'b1, 1'b1, 1);

    // Randomized traffic with arrivals, ties, losses and completions.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N_MB; i++) begin
        if (!mb_v[i] && $urandom_range(0, 1) == 1)
          set_mb(i, ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 3)) : 11'($urandom),
                 4'($urandom), {$urandom, $urandom});
      end
      if (pick() < 0) set_mb(it % N_MB, 11'($urandom), 4'($urandom), {$urandom, $urandom});
      drive_reqs();
      wait_start(-1);
      r = $urandom_range(0, 9);
      finish_frame(r < 5, r >= 4, $urandom_range(0, 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
